// File: rtl/cic_comp_fir.sv
// Serial-MAC CIC droop-compensation FIR. Latency is TAPS+2 clocks from input strobe to output strobe.
// There is no backpressure: a strobe while busy is dropped and sets overrun. CIC_COMP_SAT_EN selects saturating output.
module cic_comp_fir #(
  parameter int width_H = 5,
  parameter int width_W = 20,
  parameter int TAPS    = 16,
  parameter int COEF_W  = 18,
  parameter int SHIFT   = 14,
  parameter int OUT_W   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            data_i_en,
  input  logic [width_H+width_W-1:0]      data_i,
  input  logic                            coef_we,
  input  logic [$clog2(TAPS)-1:0]         coef_addr,
  input  logic [COEF_W-1:0]               coef_data,
  input  logic                            clr_ovr,
  output logic                            busy,
  output logic                            overrun,
  output logic                            data_o_en,
  output logic signed [OUT_W-1:0]         data_o
);

  localparam int IN_W   = width_H + width_W;
  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = IN_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;

  localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1) << SHIFT;
  localparam logic signed [ACC_W-1:0]  HALF  = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0]  MAX_V = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  MIN_V = ~MAX_V;
  localparam logic [AW-1:0]            LAST  = AW'(TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  state_t                    state;
  logic signed [IN_W-1:0]    hist [TAPS];
  logic signed [COEF_W-1:0]  coef [TAPS];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             k;
  logic signed [ACC_W-1:0]   acc;
  logic signed [OUT_W-1:0]   r_lim;

  // wr_ptr already points one past the newest sample, so x[n-k] lives at wr_ptr-1-k
  logic [AW-1:0]             rd_idx;
  logic signed [IN_W-1:0]    x_rd;
  logic signed [COEF_W-1:0]  c_rd;
  logic signed [PROD_W-1:0]  x_ext;
  logic signed [PROD_W-1:0]  c_ext;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   r;
  logic signed [OUT_W-1:0]   lim;

  assign rd_idx   = wr_ptr - AW'(1) - k;
  assign x_rd     = hist[rd_idx];
  assign c_rd     = coef[k];
  assign x_ext    = {{(PROD_W-IN_W){x_rd[IN_W-1]}}, x_rd};
  assign c_ext    = {{(PROD_W-COEF_W){c_rd[COEF_W-1]}}, c_rd};
  assign prod     = x_ext * c_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign r        = (acc + HALF) >>> SHIFT;

  always_comb begin
`ifdef CIC_COMP_SAT_EN
    if (r > MAX_V)
      lim = MAX_V[OUT_W-1:0];
    else if (r < MIN_V)
      lim = MIN_V[OUT_W-1:0];
    else
      lim = r[OUT_W-1:0];
`else
    lim = OUT_W'(r);
`endif
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      k         <= '0;
      acc       <= '0;
      r_lim     <= '0;
      data_o    <= '0;
      data_o_en <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      data_o_en <= 1'b0;

      // a drop in the same cycle as clr_ovr keeps the flag set
      if (data_i_en && state != S_IDLE)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (coef_we)
            coef[coef_addr] <= coef_data;
          if (data_i_en) begin
            hist[wr_ptr] <= data_i;
            wr_ptr       <= wr_ptr + AW'(1);
            acc          <= '0;
            k            <= '0;
            state        <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          k   <= k + AW'(1);
          if (k == LAST)
            state <= S_ROUND;
        end
        S_ROUND: begin
          r_lim <= lim;
          state <= S_OUT;
        end
        S_OUT: begin
          data_o    <= r_lim;
          data_o_en <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: directed cases plus randomized traffic against a tap-sum reference model.
module tb_cic_comp_fir;
  localparam int IN_W   = 25;
  localparam int TAPS   = 16;
  localparam int AW     = 4;
  localparam int COEF_W = 18;
  localparam int SHIFT  = 14;
  localparam int OUT_W  = 16;
  localparam int LAT    = TAPS + 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     data_i_en = 1'b0;
  logic [IN_W-1:0]          data_i = '0;
  logic                     coef_we = 1'b0;
  logic [AW-1:0]            coef_addr = '0;
  logic [COEF_W-1:0]        coef_data = '0;
  logic                     clr_ovr = 1'b0;
  logic                     busy;
  logic                     overrun;
  logic                     data_o_en;
  logic signed [OUT_W-1:0]  data_o;

  always #5 clk = ~clk;

  cic_comp_fir dut (
    .clk(clk), .rst(rst), .data_i_en(data_i_en), .data_i(data_i),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .clr_ovr(clr_ovr), .busy(busy), .overrun(overrun),
    .data_o_en(data_o_en), .data_o(data_o)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: coefficient table, history with index 0 = newest sample
  typedef struct { longint val; longint due; } exp_t;
  exp_t   expq[$];
  exp_t   cur;
  longint m_coef [TAPS];
  longint m_hist [TAPS];
  longint next_free;
  longint last_acc;
  bit     m_ovr;
  longint m_dato;

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_coef[i] = (i == 0) ? (longint'(1) << SHIFT) : 0;
      m_hist[i] = 0;
    end
    next_free = 0;
    last_acc  = -100;
    m_ovr     = 1'b0;
    m_dato    = 0;
    expq.delete();
  endfunction

  function automatic longint model_out();
    longint acc, r, hi, lo;
    logic signed [OUT_W-1:0] t;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += m_coef[i] * m_hist[i];
    r  = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
`ifdef CIC_COMP_SAT_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    t = r[OUT_W-1:0];
    r = t;
`endif
    return r;
  endfunction

  // One clock of stimulus; the model decides acceptance from the sample edge number
  task automatic drive(input bit en, input longint x, input bit we, input int a, input longint d,
                       input bit clr, input bit use_c, input longint c);
    longint e;
    bit     idle_ok;
    @(negedge clk);
    data_i_en = en;
    data_i    = x[IN_W-1:0];
    coef_we   = we;
    coef_addr = a[AW-1:0];
    coef_data = d[COEF_W-1:0];
    clr_ovr   = clr;
    @(posedge clk);
    #1;
    data_i_en = 1'b0;
    coef_we   = 1'b0;
    clr_ovr   = 1'b0;
    e = cyc;
    idle_ok = (e >= next_free);
    if (we && idle_ok) m_coef[a] = d;
    if (en) begin
      if (idle_ok) begin
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = x;
        expq.push_back('{use_c ? c : model_out(), e + LAT});
        next_free = e + TAPS + 3;
        last_acc  = e;
      end else begin
        m_ovr = 1'b1;
      end
    end
    if (clr && !(en && !idle_ok)) m_ovr = 1'b0;
  endtask

  task automatic send(input longint x, input bit use_c, input longint c);
    drive(1'b1, x, 1'b0, 0, 0, 1'b0, use_c, c);
  endtask

  task automatic wcoef(input int a, input longint d);
    drive(1'b0, 0, 1'b1, a, d, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * LAT && expq.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  // Monitor: pops expected outputs and checks status every cycle
  always @(negedge clk) begin
    if (data_o_en) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: data_o_en with data_o=%0d, nothing expected (cycle %0d)", data_o, cyc);
      end else begin
        cur = expq.pop_front();
        checks++;
        if (longint'(data_o) != cur.val) begin
          errors++;
          $display("FAIL data_o: got %0d expected %0d (cycle %0d)", data_o, cur.val, cyc);
        end
        if (cyc != cur.due) begin
          errors++;
          $display("FAIL latency: strobe at cycle %0d expected at %0d", cyc, cur.due);
        end
        m_dato = cur.val;
      end
    end else begin
      checks++;
      if (longint'(data_o) != m_dato) begin
        errors++;
        $display("FAIL data_o_hold: got %0d expected %0d (cycle %0d)", data_o, m_dato, cyc);
      end
    end
    if (expq.size() > 0 && cyc > expq[0].due) begin
      checks++;
      errors++;
      $display("FAIL missing_out: no data_o_en by cycle %0d, expected %0d", expq[0].due, expq[0].val);
      void'(expq.pop_front());
    end
    checks += 2;
    if (busy !== ((cyc >= last_acc) && (cyc < last_acc + LAT))) begin
      errors++;
      $display("FAIL busy: got %0b at cycle %0d", busy, cyc);
    end
    if (overrun !== m_ovr) begin
      errors++;
      $display("FAIL overrun: got %0b expected %0b (cycle %0d)", overrun, m_ovr, cyc);
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    longint e0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Pass-through defaults
    send(1000, 1'b1, 1000);
    repeat (20) @(posedge clk);
    send(1000, 1'b1, 1000);
    drain();

    // Impulse through four taps
    do_reset();
    wcoef(0, 16384); wcoef(1, 8192); wcoef(2, 4096); wcoef(3, -16384);
    send(100, 1'b1, 100);  repeat (19) @(posedge clk);
    send(0, 1'b1, 50);     repeat (19) @(posedge clk);
    send(0, 1'b1, 25);     repeat (19) @(posedge clk);
    send(0, 1'b1, -100);   repeat (19) @(posedge clk);
    send(0, 1'b1, 0);
    drain();

    // Round half up
    do_reset();
    wcoef(0, 8192);
    send(3, 1'b1, 2);   repeat (20) @(posedge clk);
    send(-3, 1'b1, -1); repeat (20) @(posedge clk);
    send(2, 1'b1, 1);
    drain();

    // Output limiting
    do_reset();
`ifdef CIC_COMP_SAT_EN
    send(40000, 1'b1, 32767);   repeat (20) @(posedge clk);
    send(-40000, 1'b1, -32768);
`else
    send(40000, 1'b1, -25536);  repeat (20) @(posedge clk);
    send(-40000, 1'b1, 25536);
`endif
    drain();

    // Overrun: second strobe three cycles later is dropped
    do_reset();
    send(5, 1'b1, 5);
    repeat (2) @(posedge clk);
    send(9, 1'b0, 0);
    repeat (3) @(posedge clk);
    drive(1'b1, 11, 1'b1, 2, 777, 1'b1, 1'b0, 0);   // drop + clr + ignored coef write
    drain();
    wcoef(0, 0);
    // Same-cycle coef write is used by this sample: output is x[n-1], i.e. the first sample
    drive(1'b1, 0, 1'b1, 1, 16384, 1'b0, 1'b1, 5);
    drain();
    drive(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 0);
    repeat (2) @(posedge clk);

    // Reset in the middle of the MAC
    do_reset();
    send(123, 1'b0, 0);
    e0 = cyc;
    while (cyc < e0 + 4) @(posedge clk);
    do_reset();
    repeat (LAT + 4) @(posedge clk);
    send(7, 1'b1, 7);
    drain();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      longint x, d;
      int     gap;
      bit     big;
      big = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        d = big ? longint'($urandom_range(0, 262143)) - 131072
                : longint'($urandom_range(0, 40000)) - 20000;
        wcoef($urandom_range(0, TAPS - 1), d);
      end
      x = big ? longint'($urandom_range(0, 33554431)) - 16777216
              : longint'($urandom_range(0, 10000)) - 5000;
      d = longint'($urandom_range(0, 40000)) - 20000;
      drive(1'b1, x, ($urandom_range(0, 7) == 0), $urandom_range(0, TAPS - 1), d,
            ($urandom_range(0, 5) == 0), 1'b0, 0);
      gap = (n % 5 == 0) ? $urandom_range(0, 17) : $urandom_range(18, 24);
      repeat (gap) @(posedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
